// File: rtl/seq_pair_loader.sv
// Streams 2-bit bases into a 12-base R/Q pair, drives the aligner, registers its result.
// Optional WAIT timeout is enabled with SEQ_LOADER_TIMEOUT_EN.
module seq_pair_loader #(
    parameter int SEQ_LEN     = 12,
    parameter int BASE_W      = 2,
    parameter int ALN_LEN     = 15,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BASE_W-1:0]         in_base,
    output logic                      acc_start,
    output logic [SEQ_LEN*BASE_W-1:0] acc_R,
    output logic [SEQ_LEN*BASE_W-1:0] acc_Q,
    input  logic                      acc_ready,
    input  logic [ALN_LEN*BASE_W-1:0] acc_R_aligned,
    input  logic [ALN_LEN*BASE_W-1:0] acc_Q_aligned,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ALN_LEN*BASE_W-1:0] out_R_aligned,
    output logic [ALN_LEN*BASE_W-1:0] out_Q_aligned,
    output logic                      out_err,
    output logic [7:0]                pair_count
);

    localparam int SW    = SEQ_LEN * BASE_W;
    localparam int CNT_W = $clog2(SEQ_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEQ_LEN - 1);
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        LOAD_R,
        LOAD_Q,
        START,
        WAIT,
        OUTPUT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0] cnt;
    logic             ready_q;
    logic             last_beat;
    logic             ld_r;
    logic             ld_q;
    logic             done;
    logic             timeout;
    logic             to_hit;
    logic             accept;

    assign last_beat = (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        acc_start = 1'b0;
        out_valid = 1'b0;
        ld_r      = 1'b0;
        ld_q      = 1'b0;
        done      = 1'b0;
        timeout   = 1'b0;
        accept    = 1'b0;
        unique case (state)
            LOAD_R: begin
                in_ready = !reset;
                ld_r     = in_valid && !reset;
                if (ld_r && last_beat) state_nxt = LOAD_Q;
            end
            LOAD_Q: begin
                in_ready = !reset;
                ld_q     = in_valid && !reset;
                if (ld_q && last_beat) state_nxt = START;
            end
            START: begin
                acc_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // rising edge only: a level left high by the last job is not done
                done    = acc_ready && !ready_q;
                timeout = to_hit && !done;
                if (done || timeout) state_nxt = OUTPUT;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                accept    = out_ready;
                if (accept) state_nxt = LOAD_R;
            end
            default: state_nxt = LOAD_R;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOAD_R;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (ld_r || ld_q) begin
            cnt <= last_beat ? '0 : cnt + 1'b1;
        end else if (accept) begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_R <= '0;
            acc_Q <= '0;
        end else if (ld_r) begin
            acc_R <= {acc_R[SW-BASE_W-1:0], in_base};
        end else if (ld_q) begin
            acc_Q <= {acc_Q[SW-BASE_W-1:0], in_base};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
        end else if (state == START) begin
            ready_q <= 1'b1;
        end else if (state == WAIT) begin
            ready_q <= acc_ready;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_R_aligned <= '0;
            out_Q_aligned <= '0;
        end else if (done) begin
            out_R_aligned <= acc_R_aligned;
            out_Q_aligned <= acc_Q_aligned;
        end else if (timeout) begin
            out_R_aligned <= '0;
            out_Q_aligned <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       pair_count <= 8'd0;
        else if (accept) pair_count <= pair_count + 8'd1;
    end

`ifdef SEQ_LOADER_TIMEOUT_EN
    logic [9:0] to_cnt;

    assign to_hit = (state == WAIT) && (to_cnt == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state == START) begin
            to_cnt <= '0;
        end else if (state == WAIT) begin
            to_cnt <= to_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        out_err <= 1'b0;
        else if (done)    out_err <= 1'b0;
        else if (timeout) out_err <= 1'b1;
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TO_LAST;
    assign to_hit         = 1'b0;
    assign out_err        = 1'b0;
`endif

endmodule

// File: tb/tb_seq_pair_loader.sv
// Directed bench for seq_pair_loader with a job-level reference model.
// Define SEQ_LOADER_TIMEOUT_EN for both bench and RTL to test the timeout build.
module tb_seq_pair_loader;

`ifdef SEQ_LOADER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_base;
    logic        acc_start;
    logic [23:0] acc_R;
    logic [23:0] acc_Q;
    logic        acc_ready;
    logic [29:0] acc_R_aligned;
    logic [29:0] acc_Q_aligned;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] out_R_aligned;
    logic [29:0] out_Q_aligned;
    logic        out_err;
    logic [7:0]  pair_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_pair_loader dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_base      (in_base),
        .acc_start    (acc_start),
        .acc_R        (acc_R),
        .acc_Q        (acc_Q),
        .acc_ready    (acc_ready),
        .acc_R_aligned(acc_R_aligned),
        .acc_Q_aligned(acc_Q_aligned),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_R_aligned(out_R_aligned),
        .out_Q_aligned(out_Q_aligned),
        .out_err      (out_err),
        .pair_count   (pair_count)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Job-level model: bases received so far, result phase, accepted count
    typedef enum int {PH_LOAD, PH_START, PH_WAIT, PH_OUT} ph_t;
    ph_t         m_ph;
    int          m_n;
    int          m_wait;
    logic        m_prev;
    logic [23:0] m_r;
    logic [23:0] m_q;
    logic [29:0] m_or;
    logic [29:0] m_oq;
    logic        m_err;
    logic [7:0]  m_pc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ph = PH_LOAD; m_n = 0; m_wait = 0; m_prev = 1'b0;
            m_r = '0; m_q = '0; m_or = '0; m_oq = '0;
            m_err = 1'b0; m_pc = 8'd0;
        end else begin
            case (m_ph)
                PH_LOAD: if (in_valid) begin
                    if (m_n < 12) m_r = 24'(m_r * 4 + 24'(in_base));
                    else          m_q = 24'(m_q * 4 + 24'(in_base));
                    m_n++;
                    if (m_n == 24) m_ph = PH_START;
                end
                PH_START: begin
                    m_prev = 1'b1;
                    m_wait = 0;
                    m_ph = PH_WAIT;
                end
                PH_WAIT: begin
                    m_wait++;
                    if (acc_ready && !m_prev) begin
                        m_or = acc_R_aligned; m_oq = acc_Q_aligned;
                        m_err = 1'b0; m_ph = PH_OUT;
                    end else if (TO_EN && m_wait >= 1023) begin
                        m_or = '0; m_oq = '0;
                        m_err = 1'b1; m_ph = PH_OUT;
                    end
                    m_prev = acc_ready;
                end
                PH_OUT: if (out_ready) begin
                    m_pc++;
                    m_n = 0;
                    m_ph = PH_LOAD;
                end
                default: m_ph = PH_LOAD;
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        chk("m_in_ready", in_ready, (m_ph == PH_LOAD) && !reset);
        chk("m_acc_start", acc_start, m_ph == PH_START);
        chk("m_acc_R", acc_R, m_r);
        chk("m_acc_Q", acc_Q, m_q);
        chk("m_out_valid", out_valid, m_ph == PH_OUT);
        chk("m_out_R", out_R_aligned, m_or);
        chk("m_out_Q", out_Q_aligned, m_oq);
        chk("m_out_err", out_err, m_err);
        chk("m_pair_count", pair_count, m_pc);
    end

    function automatic logic [1:0] base_of(input int mode, input int i);
        if (mode == 0) return (i < 12) ? 2'(i % 4) : 2'(3 - (i % 4));
        return (i < 12) ? 2'd2 : 2'd1;
    endfunction

    // Beats of a pair starting at index first; gap inserts an idle cycle before each
    task automatic load_seq(input int mode, input bit gap,
                            input int first, input int nbeats);
        for (int i = first; i < first + nbeats; i++) begin
            if (gap) begin
                @(negedge clk); in_valid = 1'b0; in_base = 2'd3;
                @(posedge clk);
            end
            @(negedge clk); in_valid = 1'b1; in_base = base_of(mode, i);
            @(posedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [29:0] hr;
        logic [29:0] hq;
        bit seen;
        int waited;
        reset = 1'b1; in_valid = 1'b0; in_base = 2'd0; acc_ready = 1'b1;
        acc_R_aligned = '0; acc_Q_aligned = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_acc_R", acc_R, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pair_count", pair_count, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1);

        // job 1: continuous stream, stale-high acc_ready
        load_seq(0, 1'b0, 0, 24);
        #1;
        chk("j1_acc_R", acc_R, 24'h1B1B1B);
        chk("j1_acc_Q", acc_Q, 24'hE4E4E4);
        chk("j1_start", acc_start, 1);
        chk("j1_in_ready_start", in_ready, 0);
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1;
        chk("j1_start_one_cycle", acc_start, 0);
        chk("j1_in_ready_wait", in_ready, 0);
        @(posedge clk);
        @(negedge clk); acc_ready = 1'b0;
        repeat (49) @(posedge clk);
        #1 chk("j1_no_early", out_valid, 0);
        @(negedge clk);
        acc_R_aligned = 30'h12345678; acc_Q_aligned = 30'h0ABCDEF0;
        acc_ready = 1'b1;
        @(posedge clk); #1;
        chk("j1_out_valid", out_valid, 1);
        chk("j1_out_R", out_R_aligned, 30'h12345678);
        chk("j1_out_Q", out_Q_aligned, 30'h0ABCDEF0);
        chk("j1_out_err", out_err, 0);
        @(negedge clk); acc_R_aligned = 30'h3FFFFFFF; acc_Q_aligned = '0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("j1_hold_valid", out_valid, 1);
            chk("j1_hold_R", out_R_aligned, 30'h12345678);
            chk("j1_hold_Q", out_Q_aligned, 30'h0ABCDEF0);
            chk("j1_hold_count", pair_count, 0);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        chk("j1_count", pair_count, 1);
        chk("j1_valid_drop", out_valid, 0);
        chk("j1_in_ready_next", in_ready, 1);

        // job 2: gapped stream, in_valid noise in WAIT, out_ready left high
        load_seq(0, 1'b1, 0, 24);
        #1;
        chk("j2_acc_R", acc_R, 24'h1B1B1B);
        chk("j2_acc_Q", acc_Q, 24'hE4E4E4);
        chk("j2_start", acc_start, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); in_valid = k[0]; in_base = 2'(k);
        end
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1;
        chk("j2_wait_R", acc_R, 24'h1B1B1B);
        chk("j2_wait_Q", acc_Q, 24'hE4E4E4);
        chk("j2_wait_count", pair_count, 1);
        @(negedge clk); acc_ready = 1'b0;
        @(negedge clk);
        acc_R_aligned = 30'h2AAAAAAA; acc_Q_aligned = 30'h15555555;
        acc_ready = 1'b1;
        @(posedge clk); #1;
        chk("j2_out_R", out_R_aligned, 30'h2AAAAAAA);
        hr = out_R_aligned; hq = out_Q_aligned;
        @(posedge clk); #1;
        chk("j2_count", pair_count, 2);
        chk("j2_valid_drop", out_valid, 0);
        chk("j2_R_kept", out_R_aligned, 30'h2AAAAAAA);
        chk("j2_Q_kept", out_Q_aligned, 30'h15555555);

        // reset during WAIT
        @(negedge clk); out_ready = 1'b0; acc_ready = 1'b0;
        load_seq(1, 1'b0, 0, 24);
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rw_acc_R", acc_R, 0);
        chk("rw_acc_Q", acc_Q, 0);
        chk("rw_in_ready", in_ready, 0);
        chk("rw_out_R", out_R_aligned, 0);
        chk("rw_pair_count", pair_count, 0);
        @(negedge clk); reset = 1'b0;

        // reset after 5 Q beats
        load_seq(1, 1'b0, 0, 17);
        #2 reset = 1'b1;
        #1;
        chk("rq_acc_R", acc_R, 0);
        chk("rq_acc_Q", acc_Q, 0);
        chk("rq_acc_start", acc_start, 0);
        @(negedge clk); reset = 1'b0; in_valid = 1'b0;

        load_seq(1, 1'b0, 0, 23);
        @(negedge clk); in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("r23_no_start", acc_start, 0);
        chk("r23_in_ready", in_ready, 1);
        chk("r23_acc_R", acc_R, 24'hAAAAAA);
        chk("r23_acc_Q", acc_Q, 24'h155555);
        load_seq(1, 1'b0, 23, 1);
        #1;
        chk("r24_start", acc_start, 1);
        chk("r24_acc_Q", acc_Q, 24'h555555);
        @(negedge clk); in_valid = 1'b0;

`ifdef SEQ_LOADER_TIMEOUT_EN
        waited = 0;
        while (out_valid !== 1'b1 && waited < 1100) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("to_latency", waited, 1024);
        chk("to_err", out_err, 1);
        chk("to_R_zero", out_R_aligned, 0);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        chk("to_count", pair_count, 1);
`else
        seen = 1'b0;
        waited = 0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
            waited++;
        end
        chk("no_timeout_valid", seen, 0);
        chk("no_timeout_err", out_err, 0);
`endif
        hr = hr ^ hq;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
